// File: rtl/acq_sequencer_if.sv
// Host link bundle for the acquisition sequencer.
//   rxValid/rx : 32-bit command word strobe from host (opcode [31:24], arg [23:0])
//   tx/txValid/txReady : outgoing data/status word, valid/ready handshake
// master = host side, slave = sequencer side.
interface acq_sequencer_if;
  localparam int unsigned WordW = 32;

  logic             rxValid;
  logic [WordW-1:0] rx;
  logic [WordW-1:0] tx;
  logic             txValid;
  logic             txReady;

  modport master (
    output rxValid,
    output rx,
    output txReady,
    input  tx,
    input  txValid
  );

  modport slave (
    input  rxValid,
    input  rx,
    input  txReady,
    output tx,
    output txValid
  );
endinterface

// File: rtl/acq_sequencer.sv
// Single-pixel-imaging acquisition sequencer.
// For each of nPix patterns: pulse dmdTrig/cntClear, wait settleLen cycles,
// gate the photon counter for gateLen cycles, latch the count and stream it
// to the host; a final 0xFFFF_FFFF word marks the end of the run.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   host (slave) : command words in (rxValid/rx), data words out (tx/txValid/txReady)
//   dmdTrig      : one-cycle pattern-advance pulse
//   cntClear     : one-cycle photon counter clear
//   cntEn        : photon counter gate
//   cntValue     : photon counter value, valid the cycle after cntEn falls
//   busy         : high whenever the sequencer is not idle
module acq_sequencer #(
  parameter int unsigned GATE_DEFAULT   = 1000,
  parameter int unsigned SETTLE_DEFAULT = 64,
  parameter int unsigned NPIX_DEFAULT   = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  acq_sequencer_if.slave        host,
  output logic                  dmdTrig,
  output logic                  cntClear,
  output logic                  cntEn,
  input  logic [31:0]           cntValue,
  output logic                  busy
);

  localparam int unsigned WordW = 32;
  localparam int unsigned ArgW  = 24;
  localparam int unsigned OpW   = 8;

  localparam logic [OpW-1:0] OpSetGate   = 8'h01;
  localparam logic [OpW-1:0] OpSetSettle = 8'h02;
  localparam logic [OpW-1:0] OpSetNpix   = 8'h03;
  localparam logic [OpW-1:0] OpStart     = 8'h10;
  localparam logic [OpW-1:0] OpAbort     = 8'h1F;
  localparam logic [OpW-1:0] OpStatus    = 8'h20;

  localparam logic [WordW-1:0] EndMarker = 32'hFFFF_FFFF;
  localparam logic [WordW-1:0] CountMax  = 32'hFFFF_FFFE;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    TRIG   = 4'd1,
    SETTLE = 4'd2,
    GATE   = 4'd3,
    LATCH  = 4'd4,
    SEND   = 4'd5,
    END    = 4'd6
  } state_e;

  state_e           state_q, state_d;
  logic [WordW-1:0] tx_q, tx_d;
  logic             txValid_q, txValid_d;
  logic [ArgW-1:0]  gateLen_q, gateLen_d;
  logic [ArgW-1:0]  settleLen_q, settleLen_d;
  logic [ArgW-1:0]  nPix_q, nPix_d;
  logic [ArgW-1:0]  pixIdx_q, pixIdx_d;
  logic             errFlag_q, errFlag_d;
  logic [ArgW-1:0]  cnt_q, cnt_d;
  logic             dmdTrig_q, dmdTrig_d;
  logic             cntClear_q, cntClear_d;
  logic             cntEn_q, cntEn_d;
  logic             busy_q, busy_d;

  logic [OpW-1:0]   opcode;
  logic [ArgW-1:0]  arg;
  logic             is_idle;
  logic             tx_accept;
  logic [ArgW-1:0]  pixIdx_inc;

  assign opcode     = host.rx[WordW-1:ArgW];
  assign arg        = host.rx[ArgW-1:0];
  assign is_idle    = (state_q == IDLE);
  assign tx_accept  = txValid_q && host.txReady;
  assign pixIdx_inc = pixIdx_q + ArgW'(1);

  // State, registers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tx_q        <= '0;
      txValid_q   <= 1'b0;
      gateLen_q   <= ArgW'(GATE_DEFAULT);
      settleLen_q <= ArgW'(SETTLE_DEFAULT);
      nPix_q      <= ArgW'(NPIX_DEFAULT);
      pixIdx_q    <= '0;
      errFlag_q   <= 1'b0;
      cnt_q       <= '0;
      dmdTrig_q   <= 1'b0;
      cntClear_q  <= 1'b0;
      cntEn_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      txValid_q   <= txValid_d;
      gateLen_q   <= gateLen_d;
      settleLen_q <= settleLen_d;
      nPix_q      <= nPix_d;
      pixIdx_q    <= pixIdx_d;
      errFlag_q   <= errFlag_d;
      cnt_q       <= cnt_d;
      dmdTrig_q   <= dmdTrig_d;
      cntClear_q  <= cntClear_d;
      cntEn_q     <= cntEn_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, command decode and output decode
  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    txValid_d   = txValid_q;
    gateLen_d   = gateLen_q;
    settleLen_d = settleLen_q;
    nPix_d      = nPix_q;
    pixIdx_d    = pixIdx_q;
    errFlag_d   = errFlag_q;
    cnt_d       = cnt_q;

    // A word draining in IDLE can only be a status word; its acceptance clears errFlag
    if (is_idle && tx_accept) begin
      txValid_d = 1'b0;
      errFlag_d = 1'b0;
    end

    case (state_q)
      IDLE: ;
      TRIG: begin
        if (settleLen_q == '0) begin
          state_d = GATE;
          cnt_d   = gateLen_q - ArgW'(1);
        end else begin
          state_d = SETTLE;
          cnt_d   = settleLen_q - ArgW'(1);
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = GATE;
          cnt_d   = gateLen_q - ArgW'(1);
        end else begin
          cnt_d = cnt_q - ArgW'(1);
        end
      end
      GATE: begin
        if (cnt_q == '0) begin
          state_d = LATCH;
        end else begin
          cnt_d = cnt_q - ArgW'(1);
        end
      end
      LATCH: begin
        // 0xFFFF_FFFF is reserved for the end-of-run marker
        tx_d      = (cntValue == EndMarker) ? CountMax : cntValue;
        txValid_d = 1'b1;
        state_d   = SEND;
      end
      SEND: begin
        if (tx_accept) begin
          pixIdx_d = pixIdx_inc;
          if (pixIdx_inc == nPix_q) begin
            state_d   = END;
            tx_d      = EndMarker;
            txValid_d = 1'b1;
          end else begin
            state_d   = TRIG;
            txValid_d = 1'b0;
          end
        end
      end
      END: begin
        if (tx_accept) begin
          txValid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Host commands override the sequencing above
    if (host.rxValid) begin
      case (opcode)
        OpSetGate: begin
          if (!is_idle) errFlag_d = 1'b1;
          else          gateLen_d = (arg == '0) ? ArgW'(1) : arg;
        end
        OpSetSettle: begin
          if (!is_idle) errFlag_d   = 1'b1;
          else          settleLen_d = arg;
        end
        OpSetNpix: begin
          if (!is_idle) errFlag_d = 1'b1;
          else          nPix_d    = arg;
        end
        OpStart: begin
          // A pending status word must drain first, or LATCH would overwrite it
          if (!is_idle || txValid_q) begin
            errFlag_d = 1'b1;
          end else begin
            pixIdx_d = '0;
            if (nPix_q == '0) begin
              state_d   = END;
              tx_d      = EndMarker;
              txValid_d = 1'b1;
            end else begin
              state_d = TRIG;
            end
          end
        end
        OpAbort: begin
          if (!is_idle) begin
            state_d   = IDLE;
            txValid_d = 1'b0;
          end
        end
        OpStatus: begin
          if (!is_idle || txValid_q) begin
            errFlag_d = 1'b1;
          end else begin
            tx_d      = {state_q, errFlag_q, 3'b000, pixIdx_q};
            txValid_d = 1'b1;
          end
        end
        default: errFlag_d = 1'b1;
      endcase
    end

    // Outputs are decoded from the next state so they register alongside it
    dmdTrig_d  = (state_d == TRIG);
    cntClear_d = (state_d == TRIG);
    cntEn_d    = (state_d == GATE);
    busy_d     = (state_d != IDLE);
  end

  assign host.tx      = tx_q;
  assign host.txValid = txValid_q;
  assign dmdTrig      = dmdTrig_q;
  assign cntClear     = cntClear_q;
  assign cntEn        = cntEn_q;
  assign busy         = busy_q;

endmodule
